// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC cosine core's result path.
// It holds the Q1.31 input format defaults, the IEEE-754 single field widths,
// and a packed view of a single-precision word.
package cordic_pkg;

    localparam int FRAC_BITS_DEF  = 31;    // bit 31 of the magnitude weighs 1.0
    localparam int EXP_BIAS_DEF   = 127;   // IEEE-754 single exponent bias
    localparam int EXP_OFFSET_DEF = EXP_BIAS_DEF - FRAC_BITS_DEF;  // 96

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/leading_one_detect32.sv
// Combinational leading-one detector.
// Ports:
//   value : 32-bit input word
//   pos   : bit index (0..31 from LSB) of the most significant set bit
//   zero  : 1 when value has no set bit (pos is then 0 and meaningless)
module leading_one_detect32 (
    input  logic [31:0] value,
    output logic [4:0]  pos,
    output logic        zero
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                pos = 5'(i);
            end
        end
    end

    assign zero = ~|value;

endmodule

// File: rtl/cordic_fx2fp_pack.sv
// Three-stage pipelined Q1.31 magnitude + sign to IEEE-754 single converter,
// round-to-nearest-even.
// Ports:
//   clock     : rising-edge clock
//   aclr      : asynchronous active-high clear of all pipeline state
//   clk_en    : global advance enable; low freezes every register
//   in_valid / in_ready / in_mag / in_sign : input word handshake
//   out_valid / out_ready / out_fp         : result handshake
//
// Handshake: a word moves across an interface on any rising edge where
// valid and ready are both 1. A producer holding valid keeps its data
// stable until that edge; ready never depends on the valid of the same
// interface. out_fp/out_valid stay constant while out_ready is 0.
//
// Stages: S1 = input register (+ leading-one search on its output),
//         S2 = normalised mantissa/guard/sticky/exponent,
//         S3 = rounded, packed output register (out_fp/out_valid).
module cordic_fx2fp_pack
    import cordic_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int EXP_BIAS  = EXP_BIAS_DEF
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mag,
    input  logic        in_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_fp
);

    localparam int EXP_OFFSET = EXP_BIAS - FRAC_BITS;

    // Stage registers
    logic        s1_valid;
    logic        s1_sign;
    logic [31:0] s1_mag;

    logic        s2_valid;
    logic        s2_sign;
    logic        s2_zero;
    logic [22:0] s2_m;
    logic        s2_g;
    logic        s2_s;
    logic [7:0]  s2_e;

    // A stage may take new content when it is empty or its content leaves
    // this cycle; bubbles therefore collapse.
    logic s3_free;
    logic s2_free;
    logic s1_free;

    assign s3_free  = !out_valid || out_ready;
    assign s2_free  = !s2_valid  || s3_free;
    assign s1_free  = !s1_valid  || s2_free;
    assign in_ready = clk_en && s1_free;

    // S1 -> S2 combinational path: leading one, normalise, exponent
    logic [4:0]  s1_pos;
    logic        s1_zero;
    logic [31:0] s1_norm;
    logic [7:0]  s1_e;

    leading_one_detect32 u_lod (
        .value (s1_mag),
        .pos   (s1_pos),
        .zero  (s1_zero)
    );

    // Shift the leading one up to bit 31; bit 31 becomes the hidden bit.
    assign s1_norm = s1_mag << (5'd31 - s1_pos);
    assign s1_e    = 8'(EXP_OFFSET) + {3'b000, s1_pos};

    // S2 -> S3 combinational path: round to nearest even and pack
    logic        round_up;
    logic [23:0] m_sum;
    logic [7:0]  e_fin;
    fp32_t       packed_fp;

    always_comb begin
        round_up = s2_g & (s2_s | s2_m[0]);
        m_sum    = {1'b0, s2_m} + {23'd0, round_up};
        // A carry out of the mantissa leaves m_sum[22:0] = 0 and bumps the
        // exponent, i.e. 1.111..1 rounds to 2.0.
        e_fin    = s2_e + {7'd0, m_sum[23]};
        if (s2_zero) begin
            packed_fp = FP_ZERO;
        end else begin
            packed_fp.sign = s2_sign;
            packed_fp.exp  = e_fin;
            packed_fp.mant = m_sum[22:0];
        end
    end

    // S1: input register
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= 32'd0;
        end else if (clk_en && s1_free) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_mag  <= in_mag;
            end
        end
    end

    // S2: normalised fields
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_m     <= 23'd0;
            s2_g     <= 1'b0;
            s2_s     <= 1'b0;
            s2_e     <= 8'd0;
        end else if (clk_en && s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_zero <= s1_zero;
                s2_m    <= s1_norm[30:8];
                s2_g    <= s1_norm[7];
                s2_s    <= |s1_norm[6:0];
                s2_e    <= s1_e;
            end
        end
    end

    // S3: output register
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            out_valid <= 1'b0;
            out_fp    <= FP_ZERO;
        end else if (clk_en && s3_free) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_fp <= packed_fp;
            end
        end
    end

endmodule

// File: tb/tb_cordic_fx2fp_pack.sv
// Testbench for cordic_fx2fp_pack: directed spec values, randomized traffic
// against an arithmetic reference model, backpressure, clk_en freeze and
// asynchronous clear.
module tb_cordic_fx2fp_pack;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mag;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;

    always #5 clock = ~clock;

    cordic_fx2fp_pack dut (
        .clock     (clock),
        .aclr      (aclr),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [31:0] pending_exp;
    logic        last_in_fire;
    logic        last_out_fire;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // value = mag / 2^31; find k with 2^k <= mag < 2^(k+1); the 24-bit
    // significand is mag * 2^23 / 2^k rounded to nearest, ties to even.
    function automatic logic [31:0] ref_fp(input logic [31:0] mag, input logic sign);
        longint unsigned num, den, q, r;
        int k;
        int e;
        if (mag == 32'd0) return 32'h0000_0000;
        k = 0;
        while ((64'd1 << (k + 1)) <= 64'(mag)) k++;
        num = 64'(mag) << 23;
        den = 64'd1 << k;
        q   = num / den;
        r   = num % den;
        if ((2 * r > den) || ((2 * r == den) && (q % 2 == 1))) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            k = k + 1;
        end
        e = k - 31 + 127;
        return {sign, 8'(e), 23'(q)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] mag, input logic s, input logic [31:0] e);
        in_valid    = v;
        in_mag      = mag;
        in_sign     = s;
        pending_exp = e;
    endtask

    // One clock: sample handshakes at the falling edge, then pass the rising edge.
    task automatic step();
        @(negedge clock);
        last_out_fire = out_valid && out_ready && clk_en;
        last_in_fire  = in_valid && in_ready;
        if (last_out_fire) begin
            if (exp_q.size() == 0) check("unexpected_output", out_fp, 32'hxxxx_xxxx);
            else check("scoreboard", out_fp, exp_q.pop_front());
        end
        if (last_in_fire) exp_q.push_back(pending_exp);
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] mag, input logic s, input logic [31:0] e);
        drive(1'b1, mag, s, e);
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_in_fire) break;
        end
        check("send_accept", 32'(last_in_fire), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Empty pipeline, out_ready = 1: accept edge is edge 1, result after edge 3.
    task automatic latency_check(input string tag, input logic [31:0] mag, input logic s, input logic [31:0] e);
        drive(1'b1, mag, s, e);
        step();
        check({tag, "_accept"}, 32'(last_in_fire), 32'd1);
        in_valid = 1'b0;
        step();
        check({tag, "_not_yet"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_value"}, out_fp, e);
    endtask

    // ---------------- directed table ----------------
    localparam int NDIR = 8;
    logic [31:0] dir_mag [NDIR] = '{32'h4000_0000, 32'h0000_0001, 32'h8000_0080, 32'h8000_0180,
                                    32'h8000_00C0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    logic        dir_sgn [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] dir_exp [NDIR] = '{32'h3F00_0000, 32'h3000_0000, 32'h3F80_0000, 32'h3F80_0002,
                                    32'h3F80_0001, 32'h4000_0000, 32'h0000_0000, 32'hBF80_0000};

    function automatic logic [31:0] rand_mag();
        logic [31:0] m;
        m = $urandom;
        if ($urandom_range(0, 9) == 0) return 32'd0;
        return m >> $urandom_range(0, 31);
    endfunction

    // ---------------- main sequence ----------------
    logic [31:0] bp_mag [6];
    logic        bp_sgn [6];
    logic [31:0] bp_exp [6];
    logic [31:0] hold_fp;
    logic        hold_v;
    logic        have_hold;
    int          idx;
    int          retired;
    int          gaps;
    logic [31:0] m;
    logic        sg;

    initial begin
        aclr      = 1'b1;
        clk_en    = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        last_in_fire  = 1'b0;
        last_out_fire = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_fp", out_fp, 32'h0000_0000);
        aclr = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Latency and basic value
        latency_check("lat_one", 32'h8000_0000, 1'b0, 32'h3F80_0000);
        drain();

        // Directed values back-to-back
        for (int i = 0; i < NDIR; i++) send_word(dir_mag[i], dir_sgn[i], dir_exp[i]);
        drain();

        // Random traffic with random valid/ready
        for (int i = 0; i < 300; i++) begin
            m  = rand_mag();
            sg = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 3) != 0), m, sg, ref_fp(m, sg));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Backpressure: out_ready low while 6 words are offered
        for (int i = 0; i < 6; i++) begin
            bp_mag[i] = $urandom | 32'h0100_0000;
            bp_sgn[i] = 1'($urandom_range(0, 1));
            bp_exp[i] = ref_fp(bp_mag[i], bp_sgn[i]);
        end
        out_ready = 1'b0;
        idx       = 0;
        have_hold = 1'b0;
        hold_fp   = 32'd0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, bp_mag[idx], bp_sgn[idx], bp_exp[idx]);
            step();
            if (last_in_fire) idx++;
            if (out_valid) begin
                if (!have_hold) begin
                    hold_fp   = out_fp;
                    have_hold = 1'b1;
                end else begin
                    check("stall_stable", out_fp, hold_fp);
                end
            end
        end
        check("bp_accepted", 32'(idx), 32'd3);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_value", out_fp, bp_exp[0]);
        out_ready = 1'b1;
        retired   = 0;
        gaps      = 0;
        for (int c = 0; c < 30; c++) begin
            if (retired >= 6) break;
            if (idx < 6) drive(1'b1, bp_mag[idx], bp_sgn[idx], bp_exp[idx]);
            else in_valid = 1'b0;
            step();
            if (last_in_fire) idx++;
            if (last_out_fire) retired++;
            else gaps++;
        end
        in_valid = 1'b0;
        check("bp_retired", 32'(retired), 32'd6);
        check("bp_no_gaps", 32'(gaps), 32'd0);
        drain();

        // clk_en freeze mid-stream
        for (int i = 0; i < 3; i++) begin
            m = rand_mag();
            send_word(m, 1'b0, ref_fp(m, 1'b0));
        end
        m = rand_mag();
        drive(1'b1, m, 1'b1, ref_fp(m, 1'b1));
        clk_en  = 1'b0;
        hold_fp = out_fp;
        hold_v  = out_valid;
        check("freeze_has_output", 32'(hold_v), 32'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            check("freeze_out_fp", out_fp, hold_fp);
            check("freeze_out_valid", 32'(out_valid), 32'(hold_v));
            check("freeze_in_ready", 32'(in_ready), 32'd0);
        end
        clk_en = 1'b1;
        send_word(m, 1'b1, ref_fp(m, 1'b1));
        for (int i = 0; i < 3; i++) begin
            m = rand_mag();
            send_word(m, 1'b0, ref_fp(m, 1'b0));
        end
        drain();

        // Asynchronous clear with 3 words in flight
        for (int i = 0; i < 3; i++) begin
            m = rand_mag() | 32'h0000_0100;
            send_word(m, 1'b1, ref_fp(m, 1'b1));
        end
        check("pre_clear_valid", 32'(out_valid), 32'd1);
        #1 aclr = 1'b1;
        #1;
        check("clear_out_valid", 32'(out_valid), 32'd0);
        check("clear_out_fp", out_fp, 32'h0000_0000);
        exp_q.delete();
        #1 aclr = 1'b0;
        latency_check("post_clear", 32'h4000_0000, 1'b0, 32'h3F00_0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
